// File: rtl/control_multiciclo.sv
// Moore control FSM for the multicycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/write-back
// and drives all datapath control lines from the current state.
module control_multiciclo #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  state_t state, nxt;

  // State register; reset returns to Fetch at the next edge.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt;
  end

  // Next-state and Moore outputs; reset forces every control line low in the
  // same cycle so an aborted instruction cannot write anything.
  always_comb begin
    nxt         = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    IllegalOp   = 1'b0;
    State       = state;
    case (state)
      S_FETCH: begin
        nxt     = S_DECODE;
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (Op == OP_LW || Op == OP_SW) nxt = S_MEMADDR;
        else if (Op == OP_RTYPE)        nxt = S_EXEC;
        else if (Op == OP_BEQ)          nxt = S_BRANCH;
        else if (Op == OP_J)            nxt = S_JUMP;
        else if (Op == OP_ADDI)         nxt = S_ADDIEX;
        else begin
          nxt       = S_FETCH;
          IllegalOp = 1'b1;
        end
      end
      S_MEMADDR: begin
        nxt     = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        nxt     = S_MEMWB;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        nxt     = S_ALUWB;
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        nxt     = S_ADDIWB;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: nxt = S_FETCH;  // unreachable codes fall back with outputs low
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      PCSource    = 2'b00;
      ALUOp       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      IllegalOp   = 1'b0;
      State       = 4'd0;
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: directed instruction mix, then random opcodes
// with random mid-instruction resets, checked against a path/output model.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, IllegalOp;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;

  typedef int iq_t[$];

  control_multiciclo dut (
    .clk(clk), .reset(reset), .Op(Op),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 clk = ~clk;

  // Observed controls packed in a fixed order for comparison.
  function automatic logic [17:0] obs();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, IllegalOp};
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
  endfunction

  // State trace of one instruction, from the instruction's step list.
  function automatic iq_t path(input logic [5:0] o);
    iq_t p;
    case (o)
      6'h23:   p = '{0, 1, 2, 3, 4};
      6'h2B:   p = '{0, 1, 2, 5};
      6'h00:   p = '{0, 1, 6, 7};
      6'h04:   p = '{0, 1, 8};
      6'h02:   p = '{0, 1, 9};
      6'h08:   p = '{0, 1, 10, 11};
      default: p = '{0, 1};
    endcase
    return p;
  endfunction

  // Expected controls for a state, expressed as which states assert each line.
  function automatic logic [17:0] expc(input int s, input logic [5:0] o);
    logic       pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, ill;
    logic [1:0] pcs, aop, asb;
    pcw  = s inside {0, 9};
    pcwc = (s == 8);
    iord = s inside {3, 5};
    mr   = s inside {0, 3};
    mw   = (s == 5);
    irw  = (s == 0);
    m2r  = (s == 4);
    pcs  = (s == 8) ? 2'b01 : (s == 9) ? 2'b10 : 2'b00;
    aop  = (s == 6) ? 2'b10 : (s == 8) ? 2'b01 : 2'b00;
    asa  = s inside {2, 6, 8, 10};
    asb  = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s inside {2, 10}) ? 2'b10 : 2'b00;
    rw   = s inside {4, 7, 11};
    rd   = (s == 7);
    ill  = (s == 1) && !legal(o);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, pcs, aop, asa, asb, rw, rd, ill};
  endfunction

  task automatic chk_state(input int s, input logic [5:0] o);
    total++;
    assert (State === 4'(s)) else begin
      bad++;
      $error("FAIL state op=%h got=%0d exp=%0d", o, State, s);
    end
    total++;
    assert (obs() === expc(s, o)) else begin
      bad++;
      $error("FAIL ctl op=%h st=%0d got=%b exp=%b", o, s, obs(), expc(s, o));
    end
    total++;
    assert (!(PCWrite && PCWriteCond) && !(MemRead && MemWrite)) else begin
      bad++;
      $error("FAIL excl st=%0d got=%b exp=no_overlap", s, obs());
    end
  endtask

  task automatic chk_zero(input string tag);
    total++;
    assert (obs() === 18'd0 && State === 4'd0) else begin
      bad++;
      $error("FAIL %s got=%b/%0d exp=0/0", tag, obs(), State);
    end
  endtask

  // One instruction; abort_at >= 0 asserts reset at that step for one cycle.
  task automatic run_instr(input logic [5:0] o, input int abort_at);
    iq_t p;
    p  = path(o);
    Op = o;
    for (int i = 0; i < p.size(); i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk_zero("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      chk_state(p[i], o);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [5:0] o;
    logic [5:0] ops [6];
    int ab;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    reset = 1'b1;
    Op    = 6'h00;
    @(negedge clk);
    chk_zero("rst_hold");
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero("rst_hold2");
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed: the documented sequences back to back.
    run_instr(6'h23, -1);
    run_instr(6'h2B, -1);
    run_instr(6'h00, -1);
    run_instr(6'h04, -1);
    run_instr(6'h02, -1);
    run_instr(6'h08, -1);
    run_instr(6'h3F, -1);
    run_instr(6'h23, 3);      // reset during MemRd
    run_instr(6'h23, -1);     // fresh fetch afterwards, full LW
    run_instr(6'h2B, 2);      // reset during MemAddr of SW

    // Random mix with occasional aborts.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(4) == 0) o = 6'($urandom);
      else                        o = ops[$urandom_range(5)];
      ab = ($urandom_range(7) == 0) ? $urandom_range(path(o).size() - 1) : -1;
      run_instr(o, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
